// File: rtl/sonar_medida_uc.sv
// sonar_medida_uc: control unit for one ultrasonic range measurement.
// It drives the trigger pulse and waits for the echo. It clears and watches
// contador_cm, latches the BCD distance and flags an echo timeout.
// Operation is single-shot or continuous with a fixed gap between measurements.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   medir, modo_continuo  start request (sampled in inicial); 1 = repeat
//   echo                  sensor echo (also routed to contador_cm pulso)
//   pronto_cm             end-of-count pulse from contador_cm
//   distancia_cm          3-digit BCD count from contador_cm
//   trigger, zera_cm      sensor trigger; synchronous clear of contador_cm
//   medida, pronto        last valid distance (BCD); one-cycle new-value pulse
//   timeout               sticky echo-timeout flag, cleared in preparacao
//   db_estado             current state code for debug
//
// Optional build macro SINCRONIZA_ECHO_EN inserts a 2-FF synchronizer on echo.
// It adds two cycles of echo-to-mede latency and leaves the ports unchanged.

module sonar_medida_uc #(
   parameter int TRIG_CICLOS      = 500,
   parameter int TIMEOUT_CICLOS   = 1500000,
   parameter int INTERVALO_CICLOS = 3000000,
   parameter int CNT_W            = 22
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        medir,
   input  logic        modo_continuo,
   input  logic        echo,
   input  logic        pronto_cm,
   input  logic [11:0] distancia_cm,
   output logic        trigger,
   output logic        zera_cm,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        timeout,
   output logic [3:0]  db_estado
);

   localparam logic [CNT_W-1:0] TRIG_FIM      = CNT_W'(TRIG_CICLOS - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_FIM   = CNT_W'(TIMEOUT_CICLOS - 1);
   localparam logic [CNT_W-1:0] INTERVALO_FIM = CNT_W'(INTERVALO_CICLOS - 1);

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARACAO    = 4'd1,
      ENVIA_TRIGGER = 4'd2,
      ESPERA_ECHO   = 4'd3,
      MEDE          = 4'd4,
      ARMAZENA      = 4'd5,
      FINAL         = 4'd6,
      ERRO          = 4'd7,
      INTERVALO     = 4'd8
   } estado_t;

   estado_t          estado;
   estado_t          prox;
   logic [CNT_W-1:0] cnt;
   logic             echo_fsm;

`ifdef SINCRONIZA_ECHO_EN
   logic [1:0] echo_sinc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) echo_sinc <= 2'b00;
      else       echo_sinc <= {echo_sinc[0], echo};
   end

   assign echo_fsm = echo_sinc[1];
`else
   assign echo_fsm = echo;
`endif

   // Next-state decision. The echo timeout shares cnt across espera_echo and
   // mede, so the same terminal value is checked in both states.
   always_comb begin
      prox = INICIAL;
      case (estado)
         INICIAL:       prox = medir ? PREPARACAO : INICIAL;
         PREPARACAO:    prox = ENVIA_TRIGGER;
         ENVIA_TRIGGER: prox = (cnt == TRIG_FIM) ? ESPERA_ECHO : ENVIA_TRIGGER;
         ESPERA_ECHO: begin
            if (echo_fsm)                prox = MEDE;
            else if (cnt == TIMEOUT_FIM) prox = ERRO;
            else                         prox = ESPERA_ECHO;
         end
         MEDE: begin
            // End of count wins over a timeout in the same cycle.
            if (pronto_cm)               prox = ARMAZENA;
            else if (cnt == TIMEOUT_FIM) prox = ERRO;
            else                         prox = MEDE;
         end
         ARMAZENA:      prox = FINAL;
         FINAL:         prox = modo_continuo ? INTERVALO : INICIAL;
         ERRO:          prox = modo_continuo ? INTERVALO : INICIAL;
         INTERVALO: begin
            if (!modo_continuo)            prox = INICIAL;
            else if (cnt == INTERVALO_FIM) prox = PREPARACAO;
            else                           prox = INTERVALO;
         end
         default:       prox = INICIAL;
      endcase
   end

   // State register and registered outputs. The Moore outputs are decoded
   // from the state being entered, so they change on the same edge as the
   // state and carry no extra cycle of delay.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado    <= INICIAL;
         cnt       <= '0;
         trigger   <= 1'b0;
         zera_cm   <= 1'b0;
         medida    <= 12'h000;
         pronto    <= 1'b0;
         timeout   <= 1'b0;
         db_estado <= 4'd0;
      end else begin
         estado    <= prox;
         trigger   <= (prox == ENVIA_TRIGGER);
         zera_cm   <= (prox == PREPARACAO);
         pronto    <= (prox == FINAL);
         db_estado <= prox;

         // cnt restarts on every state change except espera_echo -> mede.
         // That transition keeps counting, so the timeout covers both states.
         if ((prox != estado) && !((estado == ESPERA_ECHO) && (prox == MEDE)))
            cnt <= '0;
         else if (estado inside {ENVIA_TRIGGER, ESPERA_ECHO, MEDE, INTERVALO})
            cnt <= cnt + CNT_W'(1);

         if (estado == ARMAZENA)
            medida <= distancia_cm;

         if (prox == PREPARACAO)
            timeout <= 1'b0;
         else if (prox == ERRO)
            timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sonar_medida_uc.sv
// Directed bench for sonar_medida_uc, using small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sonar_medida_uc;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        medir = 1'b0;
   logic        modo_continuo = 1'b0;
   logic        echo = 1'b0;
   logic        pronto_cm = 1'b0;
   logic [11:0] distancia_cm = 12'h000;
   logic        trigger;
   logic        zera_cm;
   logic [11:0] medida;
   logic        pronto;
   logic        timeout;
   logic [3:0]  db_estado;

   int checks = 0;
   int errors = 0;

   sonar_medida_uc #(
      .TRIG_CICLOS(4),
      .TIMEOUT_CICLOS(40),
      .INTERVALO_CICLOS(20),
      .CNT_W(22)
   ) dut (
      .clock(clock),
      .reset(reset),
      .medir(medir),
      .modo_continuo(modo_continuo),
      .echo(echo),
      .pronto_cm(pronto_cm),
      .distancia_cm(distancia_cm),
      .trigger(trigger),
      .zera_cm(zera_cm),
      .medida(medida),
      .pronto(pronto),
      .timeout(timeout),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance until db_estado equals cod, giving up after max cycles.
   task automatic esperar(input string tag, input logic [3:0] cod, input int max);
      int n;
      n = 0;
      while (db_estado != cod && n < max) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(db_estado), 32'(cod));
   endtask

   task automatic pulso_medir();
      @(negedge clock);
      medir = 1'b1;
      @(negedge clock);
      medir = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int np;
      logic [11:0] med;
      logic [11:0] vals [3];
      vals[0] = 12'h010;
      vals[1] = 12'h020;
      vals[2] = 12'h030;

      // Reset state
      #12;
      check("rst_trigger", 32'(trigger), 32'd0);
      check("rst_zera", 32'(zera_cm), 32'd0);
      check("rst_medida", 32'(medida), 32'h000);
      check("rst_pronto", 32'(pronto), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_estado", 32'(db_estado), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("idle_estado", 32'(db_estado), 32'd0);

      // 1. Single shot
      pulso_medir();
      check("t1_prep", 32'(db_estado), 32'd1);
      check("t1_zera", 32'(zera_cm), 32'd1);
      @(negedge clock);
      check("t1_trig_rise", 32'(trigger), 32'd1);
      n = 0;
      while (trigger && n < 20) begin
         n++;
         @(negedge clock);
      end
      check("t1_trig_width", 32'(n), 32'd4);
      check("t1_espera", 32'(db_estado), 32'd3);
      echo = 1'b1;
      @(negedge clock);
      check("t1_mede", 32'(db_estado), 32'd4);
      repeat (9) @(negedge clock);
      echo = 1'b0;
      distancia_cm = 12'h123;
      pronto_cm = 1'b1;
      @(negedge clock);
      pronto_cm = 1'b0;
      check("t1_armazena", 32'(db_estado), 32'd5);
      np = 0;
      med = 12'h000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (pronto) begin
            np++;
            med = medida;
         end
      end
      check("t1_pronto_cnt", 32'(np), 32'd1);
      check("t1_medida", 32'(med), 32'h123);
      check("t1_timeout", 32'(timeout), 32'd0);
      check("t1_volta", 32'(db_estado), 32'd0);

      // 2. Timeout, echo never rises
      distancia_cm = 12'h999;
      pulso_medir();
      esperar("t2_espera", 4'd3, 20);
      n = 0;
      np = 0;
      while (db_estado == 4'd3 && n < 60) begin
         n++;
         @(negedge clock);
      end
      check("t2_ciclos", 32'(n), 32'd40);
      check("t2_erro", 32'(db_estado), 32'd7);
      check("t2_timeout", 32'(timeout), 32'd1);
      check("t2_pronto", 32'(pronto), 32'd0);
      check("t2_medida", 32'(medida), 32'h123);
      @(negedge clock);
      check("t2_inicial", 32'(db_estado), 32'd0);
      check("t2_sticky", 32'(timeout), 32'd1);

      // 3. Stuck echo, pronto_cm never comes
      pulso_medir();
      esperar("t3_espera", 4'd3, 20);
      echo = 1'b1;
      n = 0;
      while ((db_estado == 4'd3 || db_estado == 4'd4) && n < 60) begin
         n++;
         @(negedge clock);
      end
      echo = 1'b0;
      check("t3_ciclos", 32'(n), 32'd40);
      check("t3_erro", 32'(db_estado), 32'd7);
      check("t3_medida", 32'(medida), 32'h123);
      @(negedge clock);
      pulso_medir();
      check("t3_prep", 32'(db_estado), 32'd1);
      check("t3_timeout_clr", 32'(timeout), 32'd0);

      // 6. pronto_cm coincides with cnt==39 in mede
      esperar("t6_espera", 4'd3, 20);
      echo = 1'b1;
      @(negedge clock);
      check("t6_mede", 32'(db_estado), 32'd4);
      repeat (38) @(negedge clock);
      check("t6_ainda_mede", 32'(db_estado), 32'd4);
      distancia_cm = 12'h456;
      pronto_cm = 1'b1;
      @(negedge clock);
      pronto_cm = 1'b0;
      echo = 1'b0;
      check("t6_armazena", 32'(db_estado), 32'd5);
      @(negedge clock);
      check("t6_final", 32'(db_estado), 32'd6);
      check("t6_pronto", 32'(pronto), 32'd1);
      check("t6_medida", 32'(medida), 32'h456);
      check("t6_timeout", 32'(timeout), 32'd0);
      @(negedge clock);
      check("t6_inicial", 32'(db_estado), 32'd0);

      // 4. Continuous mode
      modo_continuo = 1'b1;
      pulso_medir();
      for (int i = 0; i < 3; i++) begin
         esperar("t4_espera", 4'd3, 40);
         echo = 1'b1;
         repeat (3) @(negedge clock);
         echo = 1'b0;
         distancia_cm = vals[i];
         pronto_cm = 1'b1;
         @(negedge clock);
         pronto_cm = 1'b0;
         @(negedge clock);
         check("t4_pronto", 32'(pronto), 32'd1);
         check("t4_medida", 32'(medida), 32'(vals[i]));
         @(negedge clock);
         check("t4_intervalo", 32'(db_estado), 32'd8);
         if (i < 2) begin
            n = 0;
            while (db_estado == 4'd8 && n < 40) begin
               n++;
               @(negedge clock);
            end
            check("t4_gap", 32'(n), 32'd20);
            check("t4_reprep", 32'(db_estado), 32'd1);
         end else begin
            modo_continuo = 1'b0;
            @(negedge clock);
            check("t4_aborta", 32'(db_estado), 32'd0);
            check("t4_aborta_pronto", 32'(pronto), 32'd0);
         end
      end

      // 5. Async reset during envia_trigger
      pulso_medir();
      esperar("t5_envia", 4'd2, 10);
      check("t5_trig_alto", 32'(trigger), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t5_trigger", 32'(trigger), 32'd0);
      check("t5_estado", 32'(db_estado), 32'd0);
      check("t5_zera", 32'(zera_cm), 32'd0);
      check("t5_pronto", 32'(pronto), 32'd0);
      check("t5_timeout", 32'(timeout), 32'd0);
      check("t5_medida", 32'(medida), 32'h000);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("t5_pos_reset", 32'(db_estado), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
